// File: rtl/cdr_pkg.sv
// Shared CDR definitions: loop states/codes, period and accumulator widths, loop thresholds.
// The symbol counter imports the same values so period width and nominal length always agree.
package cdr_pkg;

    localparam int P_W       = 6;
    localparam int NB_P_NOM  = 25;
    localparam int ACC_W     = 4;
    localparam int THR_ACQ   = 2;
    localparam int THR_TRK   = 4;
    localparam int LOCK_SYMS = 16;
    localparam int LOSS_SYMS = 4;

    // Counter widths sized to hold LOCK_SYMS / LOSS_SYMS without saturating early
    localparam int QCNT_W = 5;
    localparam int CCNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACQ   = 2'b01,
        TRACK = 2'b10,
        HOLD  = 2'b11
    } state_t;

endpackage

// File: rtl/cdr_vote_acc.sv
// Signed saturating early/late vote accumulator with clear and freeze; 1-cycle registered,
// no backpressure. o_acc_voted exposes this cycle's vote applied so a same-cycle update sees it.
module cdr_vote_acc
    import cdr_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clr,
    input  logic                    i_frz,
    input  logic                    i_vote_vld,
    input  logic                    i_up,
    input  logic                    i_dn,
    output logic signed [ACC_W-1:0] o_acc,
    output logic signed [ACC_W-1:0] o_acc_voted
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_voted;

    always_comb begin
        acc_voted = acc_q;
        if (i_vote_vld && !i_frz) begin
            if (i_up && !i_dn && acc_q != ACC_MAX) begin
                acc_voted = acc_q + ACC_ONE;
            end else if (i_dn && !i_up && acc_q != ACC_MIN) begin
                acc_voted = acc_q - ACC_ONE;
            end
        end
    end

    always_comb begin
        acc_d = acc_voted;
        if (i_clr) begin
            acc_d = '0;
        end else if (i_frz) begin
            acc_d = acc_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_acc       = acc_q;
    assign o_acc_voted = acc_voted;

endmodule

// File: rtl/cdr_period_ctrl.sv
// CDR loop sequencer: votes -> per-symbol period choice, acquisition/lock tracking.
// Outputs registered, valid the cycle after the strobe; strobes are never backpressured.
module cdr_period_ctrl
    import cdr_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic           i_stop,
    input  logic           i_hold,
    input  logic           i_en,
    input  logic           i_en_freq_synch,
    input  logic           i_early,
    input  logic           i_late,
    output logic [P_W-1:0] o_nb_P,
    output logic [1:0]     o_cnt_p,
    output logic           o_lock
);

    localparam logic [P_W-1:0]          NB_NOM  = P_W'(NB_P_NOM);
    localparam logic [P_W-1:0]          NB_FAST = P_W'(NB_P_NOM - 1);
    localparam logic [P_W-1:0]          NB_SLOW = P_W'(NB_P_NOM + 1);
    localparam logic signed [ACC_W-1:0] T_ACQ   = ACC_W'(THR_ACQ);
    localparam logic signed [ACC_W-1:0] T_TRK   = ACC_W'(THR_TRK);

    state_t              state_q, state_d;
    state_t              ret_q, ret_d;
    logic [P_W-1:0]      nb_p_q, nb_p_d;
    logic                lock_q, lock_d;
    logic [QCNT_W-1:0]   quiet_q, quiet_d, quiet_inc;
    logic [CCNT_W-1:0]   corr_q, corr_d, corr_inc;

    logic                    active;
    logic                    take_vote;
    logic                    acc_clr;
    logic                    acc_frz;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_voted;
    logic signed [ACC_W-1:0] thr_pos;
    logic signed [ACC_W-1:0] thr_neg;
    logic                    corr_up;
    logic                    corr_dn;

    assign active    = (state_q == ACQ) || (state_q == TRACK);
    assign take_vote = active && i_en && !i_stop && !i_hold;
    assign acc_frz   = (state_q == HOLD) || (active && i_hold);
    assign thr_pos   = (state_q == TRACK) ? T_TRK : T_ACQ;
    assign thr_neg   = -thr_pos;
    assign corr_up   = (acc_voted >= thr_pos);
    assign corr_dn   = (acc_voted <= thr_neg);
    assign quiet_inc = (&quiet_q) ? quiet_q : quiet_q + 1'b1;
    assign corr_inc  = (&corr_q) ? corr_q : corr_q + 1'b1;

    cdr_vote_acc u_acc (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (acc_clr),
        .i_frz       (acc_frz),
        .i_vote_vld  (take_vote),
        .i_up        (i_late),
        .i_dn        (i_early),
        .o_acc       (acc),
        .o_acc_voted (acc_voted)
    );

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        nb_p_d  = nb_p_q;
        lock_d  = lock_q;
        quiet_d = quiet_q;
        corr_d  = corr_q;
        acc_clr = 1'b0;
        if (i_stop) begin
            state_d = IDLE;
            nb_p_d  = NB_NOM;
            lock_d  = 1'b0;
            quiet_d = '0;
            corr_d  = '0;
            acc_clr = 1'b1;
        end else if (i_hold && active) begin
            state_d = HOLD;
            ret_d   = state_q;
            nb_p_d  = NB_NOM;
        end else if (state_q == HOLD) begin
            if (!i_hold) begin
                state_d = ret_q;
            end
        end else if (state_q == IDLE) begin
            // A held loop is not started: hold outranks start
            if (i_start && !i_hold) begin
                state_d = ACQ;
                acc_clr = 1'b1;
            end
        end else if (i_en_freq_synch) begin
            if (corr_up || corr_dn) begin
                nb_p_d  = corr_up ? NB_FAST : NB_SLOW;
                acc_clr = 1'b1;
                quiet_d = '0;
                corr_d  = corr_inc;
                if (state_q == TRACK && corr_inc == CCNT_W'(LOSS_SYMS)) begin
                    state_d = ACQ;
                    lock_d  = 1'b0;
                    corr_d  = '0;
                end
            end else begin
                nb_p_d  = NB_NOM;
                quiet_d = quiet_inc;
                corr_d  = '0;
                // Counters restart at each lock/loss so the new phase is judged afresh
                if (state_q == ACQ && quiet_inc == QCNT_W'(LOCK_SYMS)) begin
                    state_d = TRACK;
                    lock_d  = 1'b1;
                    quiet_d = '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            ret_q   <= ACQ;
            nb_p_q  <= NB_NOM;
            lock_q  <= 1'b0;
            quiet_q <= '0;
            corr_q  <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            nb_p_q  <= nb_p_d;
            lock_q  <= lock_d;
            quiet_q <= quiet_d;
            corr_q  <= corr_d;
        end
    end

    assign o_nb_P  = nb_p_q;
    assign o_cnt_p = state_q;
    assign o_lock  = lock_q;

endmodule

// File: tb/tb_cdr_period_ctrl.sv
// Directed bench for cdr_period_ctrl: reset, correction, lock/loss, saturation, hold/stop.
module tb_cdr_period_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_start = 1'b0;
    logic       i_stop = 1'b0;
    logic       i_hold = 1'b0;
    logic       i_en = 1'b0;
    logic       i_en_freq_synch = 1'b0;
    logic       i_early = 1'b0;
    logic       i_late = 1'b0;
    logic [5:0] o_nb_P;
    logic [1:0] o_cnt_p;
    logic       o_lock;

    int n_chk  = 0;
    int n_fail = 0;

    cdr_period_ctrl dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_start         (i_start),
        .i_stop          (i_stop),
        .i_hold          (i_hold),
        .i_en            (i_en),
        .i_en_freq_synch (i_en_freq_synch),
        .i_early         (i_early),
        .i_late          (i_late),
        .o_nb_P          (o_nb_P),
        .o_cnt_p         (o_cnt_p),
        .o_lock          (o_lock)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic vote(input logic late, input logic early);
        i_en = 1'b1; i_late = late; i_early = early;
        tick();
        i_en = 1'b0; i_late = 1'b0; i_early = 1'b0;
    endtask

    task automatic fsync();
        i_en_freq_synch = 1'b1;
        tick();
        i_en_freq_synch = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic pulse_stop();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
    endtask

    initial begin
        // 1: reset values, then asynchronous reset in the middle of ACQ
        #12;
        chk("rst_nb", 32'(o_nb_P), 32'd25);
        chk("rst_cnt", 32'(o_cnt_p), 32'd0);
        chk("rst_lock", 32'(o_lock), 32'd0);
        i_rst = 1'b1;
        tick();
        pulse_start();
        chk("start_cnt", 32'(o_cnt_p), 32'd1);
        vote(1'b1, 1'b0);
        vote(1'b1, 1'b0);
        #3 i_rst = 1'b0;
        #1;
        chk("arst_cnt", 32'(o_cnt_p), 32'd0);
        chk("arst_nb", 32'(o_nb_P), 32'd25);
        chk("arst_acc", 32'(dut.acc), 32'd0);
        tick();
        i_rst = 1'b1;
        tick();

        // 2: two late votes -> one short symbol
        pulse_start();
        vote(1'b1, 1'b0);
        vote(1'b1, 1'b0);
        fsync();
        chk("corr_nb", 32'(o_nb_P), 32'd24);
        chk("corr_acc", 32'(dut.acc), 32'd0);
        tick();
        chk("corr_hold_nb", 32'(o_nb_P), 32'd24);
        fsync();
        chk("quiet_nb", 32'(o_nb_P), 32'd25);
        // vote and update in the same cycle: acc 1 -> 2 reaches the threshold
        vote(1'b1, 1'b0);
        i_en = 1'b1; i_late = 1'b1; i_en_freq_synch = 1'b1;
        tick();
        i_en = 1'b0; i_late = 1'b0; i_en_freq_synch = 1'b0;
        chk("same_cyc_nb", 32'(o_nb_P), 32'd24);
        chk("same_cyc_acc", 32'(dut.acc), 32'd0);

        // 3: sixteen balanced symbols -> lock
        pulse_stop();
        pulse_start();
        for (int s = 0; s < 16; s++) begin
            vote(1'b1, 1'b0);
            vote(1'b0, 1'b1);
            fsync();
            if (s == 14) begin
                chk("prelock_lock", 32'(o_lock), 32'd0);
                chk("prelock_cnt", 32'(o_cnt_p), 32'd1);
            end
        end
        chk("lock", 32'(o_lock), 32'd1);
        chk("lock_cnt", 32'(o_cnt_p), 32'd2);

        // 4: four corrected symbols in TRACK -> loss of lock
        for (int s = 0; s < 4; s++) begin
            for (int v = 0; v < 4; v++) vote(1'b0, 1'b1);
            fsync();
            chk($sformatf("loss_nb%0d", s), 32'(o_nb_P), 32'd26);
            if (s == 2) chk("preloss_cnt", 32'(o_cnt_p), 32'd2);
        end
        chk("loss_lock", 32'(o_lock), 32'd0);
        chk("loss_cnt", 32'(o_cnt_p), 32'd1);
        chk("loss_acc", 32'(dut.acc), 32'd0);

        // 5: saturation at +7, simultaneous early/late ignored
        for (int v = 0; v < 20; v++) vote(1'b1, 1'b0);
        chk("sat_acc", 32'(dut.acc), 32'd7);
        vote(1'b1, 1'b1);
        chk("both_acc", 32'(dut.acc), 32'd7);
        vote(1'b0, 1'b1);
        chk("desat_acc", 32'(dut.acc), 32'd6);

        // 6: hold in TRACK, release, then stop with hold
        pulse_stop();
        pulse_start();
        for (int s = 0; s < 16; s++) fsync();
        chk("relock_cnt", 32'(o_cnt_p), 32'd2);
        for (int v = 0; v < 4; v++) vote(1'b1, 1'b0);
        fsync();
        chk("trk_corr_nb", 32'(o_nb_P), 32'd24);
        vote(1'b1, 1'b0);
        i_hold = 1'b1;
        tick();
        chk("hold_cnt", 32'(o_cnt_p), 32'd3);
        chk("hold_nb", 32'(o_nb_P), 32'd25);
        for (int s = 0; s < 3; s++) begin
            for (int v = 0; v < 4; v++) vote(1'b1, 1'b0);
            fsync();
        end
        chk("hold_acc", 32'(dut.acc), 32'd1);
        chk("hold_cnt2", 32'(o_cnt_p), 32'd3);
        chk("hold_nb2", 32'(o_nb_P), 32'd25);
        i_hold = 1'b0;
        tick();
        chk("rel_cnt", 32'(o_cnt_p), 32'd2);
        chk("rel_lock", 32'(o_lock), 32'd1);
        chk("rel_acc", 32'(dut.acc), 32'd1);
        i_hold = 1'b1; i_stop = 1'b1;
        tick();
        i_hold = 1'b0; i_stop = 1'b0;
        chk("stop_cnt", 32'(o_cnt_p), 32'd0);
        chk("stop_lock", 32'(o_lock), 32'd0);
        chk("stop_acc", 32'(dut.acc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
